// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, decode-side valid/ready handshake and redirect/halt control.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  Address;
  logic [INSTR_WIDTH-1:0] ReadData;
  logic [INSTR_WIDTH-1:0] Instr;
  logic [ADDR_WIDTH-1:0]  InstrPC;
  logic                   InstrValid;
  logic                   InstrReady;
  logic                   Redirect;
  logic [ADDR_WIDTH-1:0]  RedirectPC;
  logic                   Halted;

  modport master (
    output Address, Instr, InstrPC, InstrValid, Halted,
    input  ReadData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  Address, Instr, InstrPC, InstrValid, Halted,
    output ReadData, InstrReady, Redirect, RedirectPC
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues word addresses to a synchronous memory and queues returned words
// in a 2-entry buffer for decode, with redirect flush and end-of-program drain/halt.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR   = 31
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALTED} state_t;

  state_t                 r_state, w_state_n;
  logic [ADDR_WIDTH-1:0]  r_pc, r_tag;
  logic                   r_inflight;
  logic [1:0]             r_count;
  logic [INSTR_WIDTH-1:0] r_instr0, r_instr1;
  logic [ADDR_WIDTH-1:0]  r_ipc0, r_ipc1;

  logic       w_pop, w_push, w_issue, w_credit, w_at_last;
  logic [1:0] w_after_pop;
  logic [2:0] w_occupancy;

  assign w_pop       = (r_count != 2'd0) & bus.InstrReady;
  assign w_push      = r_inflight & ~bus.Redirect;
  assign w_after_pop = r_count - {1'b0, w_pop};
  // Slots already committed (buffered + in flight) after this edge's pop bound the next issue.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit    = (w_occupancy < 3'd2);
  assign w_at_last   = (r_pc == LAST_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_FETCH;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    if (bus.Redirect) begin
      w_state_n = (bus.RedirectPC > LAST_ADDR) ? S_DRAIN : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_credit) begin
            w_issue = 1'b1;
            if (w_at_last) w_state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_count == 2'd0) && !r_inflight) w_state_n = S_HALTED;
        end
        default: w_state_n = r_state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_instr0   <= '0;
      r_instr1   <= '0;
      r_ipc0     <= '0;
      r_ipc1     <= '0;
    end else if (bus.Redirect) begin
      r_pc       <= bus.RedirectPC;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        if (!w_at_last) r_pc <= r_pc + 1'b1;
      end
      r_count <= w_after_pop + {1'b0, w_push};
      if (w_pop) begin
        r_instr0 <= r_instr1;
        r_ipc0   <= r_ipc1;
      end
      // A push lands in the first free slot after the head has shifted out.
      if (w_push) begin
        if (w_after_pop == 2'd0) begin
          r_instr0 <= bus.ReadData;
          r_ipc0   <= r_tag;
        end else begin
          r_instr1 <= bus.ReadData;
          r_ipc1   <= r_tag;
        end
      end
    end
  end

  assign bus.Address    = r_pc;
  assign bus.Instr      = r_instr0;
  assign bus.InstrPC    = r_ipc0;
  assign bus.InstrValid = (r_count != 2'd0);
  assign bus.Halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stream, stall, redirect, end-of-program halt, async reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rdata = 32'h0;
  int          checks = 0;
  int          errors = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (32'd0),
    .LAST_ADDR  (32'd31)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word n holds A000_0000 + n; out-of-range reads return a marker.
  always @(posedge clk)
    rdata <= (bus.Address <= 32'd31) ? (32'hA000_0000 | bus.Address) : 32'hDEAD_BEEF;
  assign bus.ReadData = rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.InstrReady = 1'b1;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'd0;

    // Test 1: reset state, then streaming after release
    step(); step();
    chk("rst_valid",  bus.InstrValid, 0);
    chk("rst_addr",   bus.Address,    0);
    chk("rst_halted", bus.Halted,     0);
    chk("rst_instr",  bus.Instr,      0);
    chk("rst_pc",     bus.InstrPC,    0);
    #4 rst_n = 1'b1;
    step();
    chk("t1_valid_e1", bus.InstrValid, 0);
    chk("t1_addr_e1",  bus.Address,    1);
    step();
    chk("t1_valid_e2", bus.InstrValid, 1);
    chk("t1_pc_e2",    bus.InstrPC,    0);
    chk("t1_instr_e2", bus.Instr,      32'hA000_0000);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_stream_pc",    bus.InstrPC,    i);
      chk("t1_stream_instr", bus.Instr,      32'hA000_0000 + i);
      chk("t1_stream_valid", bus.InstrValid, 1);
    end

    // Test 2: stall decode for 5 cycles after first valid
    rst_n = 1'b0;
    bus.InstrReady = 1'b0;
    step();
    #4 rst_n = 1'b1;
    step(); step();
    chk("t2_first_pc", bus.InstrPC, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_pc",    bus.InstrPC,    0);
      chk("t2_hold_valid", bus.InstrValid, 1);
      chk("t2_frozen_addr", bus.Address,   2);
    end
    bus.InstrReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t2_resume_pc",    bus.InstrPC, i);
      chk("t2_resume_instr", bus.Instr,   32'hA000_0000 + i);
    end

    // Test 3: redirect to 16 with 5,6 buffered and 7 on the address bus
    bus.InstrReady = 1'b0;
    step();
    chk("t3_pre_head", bus.InstrPC, 5);
    chk("t3_pre_addr", bus.Address, 7);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'd16;
    bus.InstrReady = 1'b1;
    step();
    bus.Redirect = 1'b0;
    chk("t3_flush_valid", bus.InstrValid, 0);
    chk("t3_flush_addr",  bus.Address,    16);
    step();
    chk("t3_gap_valid", bus.InstrValid, 0);
    step();
    chk("t3_new_valid", bus.InstrValid, 1);
    chk("t3_new_pc",    bus.InstrPC,    16);
    chk("t3_new_instr", bus.Instr,      32'hA000_0010);
    step();
    chk("t3_next_pc", bus.InstrPC, 17);

    // Test 4: run 28..31 then drain and halt
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'd28;
    step();
    bus.Redirect = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_pc",     bus.InstrPC,    28 + i);
      chk("t4_valid",  bus.InstrValid, 1);
      chk("t4_halted", bus.Halted,     0);
    end
    chk("t4_addr_last", bus.Address, 31);
    step();
    chk("t4_empty_valid", bus.InstrValid, 0);
    chk("t4_no_wrap",     bus.Address,    31);
    step();
    chk("t4_halted_on",  bus.Halted,  1);
    chk("t4_addr_stays", bus.Address, 31);
    step();
    chk("t4_halted_stays", bus.Halted,     1);
    chk("t4_halt_novalid", bus.InstrValid, 0);

    // Test 5: redirect out of HALTED
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'd2;
    step();
    bus.Redirect = 1'b0;
    chk("t5_halted_off", bus.Halted,     0);
    chk("t5_addr",       bus.Address,    2);
    chk("t5_valid_e1",   bus.InstrValid, 0);
    step();
    chk("t5_valid_e2", bus.InstrValid, 0);
    step();
    chk("t5_valid_e3", bus.InstrValid, 1);
    chk("t5_pc",       bus.InstrPC,    2);
    chk("t5_instr",    bus.Instr,      32'hA000_0002);

    // Test 6: asynchronous reset mid-stream
    step();
    chk("t6_pre_pc", bus.InstrPC, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", bus.InstrValid, 0);
    chk("t6_async_addr",  bus.Address,    0);
    chk("t6_async_pc",    bus.InstrPC,    0);
    step();
    #4 rst_n = 1'b1;
    step();
    chk("t6_valid_e1", bus.InstrValid, 0);
    step();
    chk("t6_valid_e2", bus.InstrValid, 1);
    chk("t6_pc_e2",    bus.InstrPC,    0);
    step();
    chk("t6_pc_e3", bus.InstrPC, 1);

    // Test 7: redirect beyond LAST_ADDR halts without issuing
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'd40;
    step();
    bus.Redirect = 1'b0;
    chk("t7_valid",   bus.InstrValid, 0);
    chk("t7_halted0", bus.Halted,     0);
    chk("t7_addr",    bus.Address,    40);
    step();
    chk("t7_halted1", bus.Halted,     1);
    step();
    chk("t7_novalid", bus.InstrValid, 0);
    chk("t7_addr_held", bus.Address,  40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
